// File: rtl/trg_clk_pkg.sv
// Shared types and helpers for the trigger-clock start controller.
// Holds the state encoding, the majority vote primitive and the output decode.
package trg_clk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOCK_FILT = 3'd1,
    ST_HOLD      = 3'd2,
    ST_W4_SYNC   = 3'd3,
    ST_RUN       = 3'd4,
    ST_PHS_CHNG  = 3'd5,
    ST_FAIL      = 3'd6,
    ST_BAD       = 3'd7
  } state_t;

  localparam int OUT_W = 4;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Packed as {GTX_RST, TRG_RST, RUNNING, FAIL}; unknown codes decode like IDLE.
  function automatic logic [OUT_W-1:0] out_decode(input state_t s);
    case (s)
      ST_W4_SYNC: return 4'b0100;
      ST_RUN:     return 4'b0010;
      ST_FAIL:    return 4'b1101;
      default:    return 4'b1100;
    endcase
  endfunction

endpackage

// File: rtl/trg_clk_strt_ctrl_tmr_vote.sv
// Bitwise three-way majority voter for one triplicated register group.
module tmr_vote
  import trg_clk_pkg::*;
#(
  parameter int W = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] y_dummy_unused_never = '0,
  output logic [W-1:0] y
);

  always_comb begin
    y = '0;
    for (int i = 0; i < W; i++) begin
      y[i] = maj3(a[i], b[i], c[i]);
    end
  end

endmodule

// File: rtl/trg_clk_strt_ctrl.sv
// Sequences GTX and trigger-logic resets from MMCM lock, phase-change requests
// and per-channel TX sync, with lock debounce, retry/timeout handling and optional TMR.
module trg_clk_strt_ctrl
  import trg_clk_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int LOCK_FILT = 8,
  parameter int RST_HOLD  = 16,
  parameter int SYNC_TMO  = 1024,
  parameter int MAX_RETRY = 3,
  parameter int TMR       = 1,
  localparam int RCW      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            MMCM_LOCK,
  input  logic            CLK_PHS_CHNG,
  input  logic [N_CH-1:0] SYNC_DONE,
  input  logic [N_CH-1:0] CH_EN,
  output logic            GTX_RST,
  output logic            TRG_RST,
  output logic            RUNNING,
  output logic            FAIL,
  output logic [RCW-1:0]  RETRY_CNT,
  output logic [2:0]      STATE
);

  localparam int TMAX = max3(LOCK_FILT, RST_HOLD, SYNC_TMO);
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0]  LF_LAST  = TW'(LOCK_FILT - 1);
  localparam logic [TW-1:0]  RH_LAST  = TW'(RST_HOLD - 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(SYNC_TMO - 1);
  localparam logic [RCW-1:0] RC_MAX   = RCW'(MAX_RETRY);

  state_t           st_q0, st_q1, st_q2, st_v, st_nxt;
  logic [2:0]       st_vr;
  logic [RCW-1:0]   rc_q0, rc_q1, rc_q2, rc_v, rc_nxt;
  logic [OUT_W-1:0] oq0, oq1, oq2, ov, o_nxt;
  logic [TW-1:0]    timer;
  logic             tmr_inc;
  logic             all_sync;

  assign all_sync = &(SYNC_DONE | ~CH_EN);

  // Next state and retry count are derived from the voted copies only.
  always_comb begin
    st_nxt  = st_v;
    rc_nxt  = rc_v;
    tmr_inc = 1'b0;
    case (st_v)
      ST_IDLE: begin
        if (MMCM_LOCK) st_nxt = ST_LOCK_FILT;
      end
      ST_LOCK_FILT: begin
        if (!MMCM_LOCK)             st_nxt = ST_IDLE;
        else if (timer == LF_LAST)  st_nxt = ST_HOLD;
        else                        tmr_inc = 1'b1;
      end
      ST_HOLD: begin
        if (!MMCM_LOCK)             st_nxt = ST_IDLE;
        else if (timer == RH_LAST)  st_nxt = ST_W4_SYNC;
        else                        tmr_inc = 1'b1;
      end
      ST_W4_SYNC: begin
        if (!MMCM_LOCK)             st_nxt = ST_IDLE;
        else if (all_sync)          st_nxt = ST_RUN;
        else if (timer == TMO_LAST) begin
          if (rc_v >= RC_MAX) begin
            st_nxt = ST_FAIL;
          end else begin
            rc_nxt = rc_v + RCW'(1);
            st_nxt = ST_HOLD;
          end
        end else begin
          tmr_inc = 1'b1;
        end
      end
      ST_RUN: begin
        if (!MMCM_LOCK)             st_nxt = ST_IDLE;
        else if (CLK_PHS_CHNG)      st_nxt = ST_PHS_CHNG;
        else if (!all_sync)         st_nxt = ST_HOLD;
      end
      ST_PHS_CHNG: begin
        if (!CLK_PHS_CHNG)          st_nxt = ST_IDLE;
      end
      ST_FAIL: begin
        if (!MMCM_LOCK)             st_nxt = ST_IDLE;
      end
      default: st_nxt = ST_IDLE;
    endcase
    if (st_nxt == ST_IDLE || st_nxt == ST_RUN) rc_nxt = '0;
    o_nxt = out_decode(st_nxt);
  end

  // Shared, non-triplicated timer; any state change restarts it.
  always_ff @(posedge CLK) begin
    if (RST)                 timer <= '0;
    else if (st_nxt != st_v) timer <= '0;
    else if (tmr_inc)        timer <= timer + TW'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      st_q0 <= ST_IDLE;
      rc_q0 <= '0;
      oq0   <= out_decode(ST_IDLE);
    end else begin
      st_q0 <= st_nxt;
      rc_q0 <= rc_nxt;
      oq0   <= o_nxt;
    end
  end

  generate
    if (TMR != 0) begin : g_tmr
      // Copies 1 and 2 load the same next value, so a single upset is outvoted and then overwritten.
      always_ff @(posedge CLK) begin
        if (RST) begin
          st_q1 <= ST_IDLE;
          st_q2 <= ST_IDLE;
          rc_q1 <= '0;
          rc_q2 <= '0;
          oq1   <= out_decode(ST_IDLE);
          oq2   <= out_decode(ST_IDLE);
        end else begin
          st_q1 <= st_nxt;
          st_q2 <= st_nxt;
          rc_q1 <= rc_nxt;
          rc_q2 <= rc_nxt;
          oq1   <= o_nxt;
          oq2   <= o_nxt;
        end
      end

      tmr_vote #(.W(3)) u_vote_st (
        .a(st_q0), .b(st_q1), .c(st_q2), .y_dummy_unused_never('0), .y(st_vr)
      );
      tmr_vote #(.W(RCW)) u_vote_rc (
        .a(rc_q0), .b(rc_q1), .c(rc_q2), .y_dummy_unused_never('0), .y(rc_v)
      );
      tmr_vote #(.W(OUT_W)) u_vote_out (
        .a(oq0), .b(oq1), .c(oq2), .y_dummy_unused_never('0), .y(ov)
      );
    end else begin : g_single
      assign st_q1 = st_q0;
      assign st_q2 = st_q0;
      assign rc_q1 = rc_q0;
      assign rc_q2 = rc_q0;
      assign oq1   = oq0;
      assign oq2   = oq0;
      assign st_vr = st_q0;
      assign rc_v  = rc_q0;
      assign ov    = oq0;
    end
  endgenerate

  assign st_v      = state_t'(st_vr);
  assign STATE     = st_vr;
  assign RETRY_CNT = rc_v;
  assign GTX_RST   = ov[3];
  assign TRG_RST   = ov[2];
  assign RUNNING   = ov[1];
  assign FAIL      = ov[0];

endmodule

// File: tb/tb_trg_clk_strt_ctrl.sv
// Directed bench for trg_clk_strt_ctrl: stimulus queues expected status snapshots,
// a negedge monitor pops and compares them against the DUT ports.
module tb_trg_clk_strt_ctrl;
  import trg_clk_pkg::*;

  logic       CLK;
  logic       RST;
  logic       MMCM_LOCK;
  logic       CLK_PHS_CHNG;
  logic [3:0] SYNC_DONE;
  logic [3:0] CH_EN;
  logic       GTX_RST;
  logic       TRG_RST;
  logic       RUNNING;
  logic       FAIL;
  logic [1:0] RETRY_CNT;
  logic [2:0] STATE;

  typedef struct packed {
    logic [2:0] st;
    logic       gtx;
    logic       trg;
    logic       run;
    logic       fail;
    logic [1:0] rc;
    logic       rc_chk;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad   = 0;

  trg_clk_strt_ctrl #(
    .N_CH(4), .LOCK_FILT(8), .RST_HOLD(16), .SYNC_TMO(1024), .MAX_RETRY(3), .TMR(1)
  ) dut (
    .CLK(CLK), .RST(RST), .MMCM_LOCK(MMCM_LOCK), .CLK_PHS_CHNG(CLK_PHS_CHNG),
    .SYNC_DONE(SYNC_DONE), .CH_EN(CH_EN), .GTX_RST(GTX_RST), .TRG_RST(TRG_RST),
    .RUNNING(RUNNING), .FAIL(FAIL), .RETRY_CNT(RETRY_CNT), .STATE(STATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic lock, input logic phs,
                               input logic [3:0] sync, input logic [3:0] en);
    MMCM_LOCK    = lock;
    CLK_PHS_CHNG = phs;
    SYNC_DONE    = sync;
    CH_EN        = en;
  endtask

  // Expected reset levels per state: IDLE/LF/HOLD/PHS 1/1, W4_SYNC 0/1, RUN 0/0, FAIL 1/1.
  task automatic checkOutput(input string name, input logic [2:0] st,
                             input logic [1:0] rc, input logic rc_chk);
    exp_t e;
    e.st     = st;
    e.gtx    = !(st == 3'd3 || st == 3'd4);
    e.trg    = (st != 3'd4);
    e.run    = (st == 3'd4);
    e.fail   = (st == 3'd6);
    e.rc     = rc;
    e.rc_chk = rc_chk;
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  always @(negedge CLK) begin
    exp_t  e;
    string n;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      total++;
      if (STATE !== e.st || GTX_RST !== e.gtx || TRG_RST !== e.trg ||
          RUNNING !== e.run || FAIL !== e.fail || (e.rc_chk && RETRY_CNT !== e.rc)) begin
        bad++;
        $display("[TB] FAIL %s: got st=%0d gtx=%b trg=%b run=%b fail=%b rc=%0d, want st=%0d gtx=%b trg=%b run=%b fail=%b rc=%0d",
                 n, STATE, GTX_RST, TRG_RST, RUNNING, FAIL, RETRY_CNT,
                 e.st, e.gtx, e.trg, e.run, e.fail, e.rc);
      end
    end
  end

  initial begin
    RST = 1'b1;
    applyStimulus(1'b1, 1'b0, 4'b0000, 4'b1111);
    tick(3);
    checkOutput("reset", 3'd0, 2'd0, 1'b1);
    RST = 1'b0;

    // Power-up: 8 debounce + 16 hold cycles, GTX_RST falls on edge 25.
    tick(1);  checkOutput("lf_enter", 3'd1, 2'd0, 1'b1);
    tick(7);  checkOutput("lf_last", 3'd1, 2'd0, 1'b1);
    tick(1);  checkOutput("hold_enter", 3'd2, 2'd0, 1'b1);
    tick(15); checkOutput("hold_last_e24", 3'd2, 2'd0, 1'b1);
    tick(1);  checkOutput("w4sync_e25", 3'd3, 2'd0, 1'b1);

    applyStimulus(1'b1, 1'b0, 4'b1111, 4'b1111);
    tick(1);  checkOutput("run_all_sync", 3'd4, 2'd0, 1'b1);

    // Masked channels: only enabled ones must be synced.
    applyStimulus(1'b1, 1'b0, 4'b0011, 4'b0011);
    tick(2);  checkOutput("run_masked", 3'd4, 2'd0, 1'b1);
    applyStimulus(1'b1, 1'b0, 4'b0010, 4'b0011);
    tick(1);  checkOutput("resync_hold", 3'd2, 2'd0, 1'b1);
    applyStimulus(1'b1, 1'b0, 4'b0011, 4'b0011);
    tick(15); checkOutput("resync_hold_last", 3'd2, 2'd0, 1'b1);
    tick(1);  checkOutput("resync_w4", 3'd3, 2'd0, 1'b1);
    tick(1);  checkOutput("resync_run", 3'd4, 2'd0, 1'b1);
    applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000);
    tick(2);  checkOutput("run_no_channels", 3'd4, 2'd0, 1'b1);

    // Phase change with MMCM_LOCK toggling underneath.
    applyStimulus(1'b1, 1'b1, 4'b0000, 4'b0000);
    tick(1);  checkOutput("phs_enter", 3'd5, 2'd0, 1'b1);
    for (int i = 1; i < 10; i++) begin
      applyStimulus((i % 2) == 0, 1'b1, 4'b0000, 4'b0000);
      tick(1); checkOutput("phs_hold", 3'd5, 2'd0, 1'b1);
    end
    applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000);
    tick(1);  checkOutput("phs_release", 3'd0, 2'd0, 1'b1);
    tick(1);  checkOutput("relock_lf", 3'd1, 2'd0, 1'b1);
    tick(23); checkOutput("relock_hold", 3'd2, 2'd0, 1'b1);
    tick(1);  checkOutput("relock_w4", 3'd3, 2'd0, 1'b1);
    tick(1);  checkOutput("relock_run", 3'd4, 2'd0, 1'b1);

    // Sync never completes: three retries then FAIL.
    applyStimulus(1'b1, 1'b0, 4'b0000, 4'b1111);
    tick(1);  checkOutput("lost_sync", 3'd2, 2'd0, 1'b1);
    tick(16); checkOutput("try0_w4", 3'd3, 2'd0, 1'b1);
    tick(1023); checkOutput("try0_last", 3'd3, 2'd0, 1'b1);
    tick(1);  checkOutput("timeout1", 3'd2, 2'd1, 1'b1);
    for (int r = 1; r < 3; r++) begin
      tick(16);   checkOutput("retry_w4", 3'd3, 2'(r), 1'b1);
      tick(1024); checkOutput("retry_timeout", 3'd2, 2'(r + 1), 1'b1);
    end
    tick(16);   checkOutput("try3_w4", 3'd3, 2'd3, 1'b1);
    tick(1023); checkOutput("try3_last", 3'd3, 2'd3, 1'b1);
    tick(1);    checkOutput("fail_enter", 3'd6, 2'd3, 1'b1);
    tick(3);    checkOutput("fail_sticky", 3'd6, 2'd3, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'b0000, 4'b1111);
    tick(1);    checkOutput("fail_unlock", 3'd0, 2'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'b1111, 4'b1111);
    tick(1);    checkOutput("fail_relock_lf", 3'd1, 2'd0, 1'b1);
    tick(24);   checkOutput("tmr_w4", 3'd3, 2'd0, 1'b1);
    tick(1);    checkOutput("tmr_run", 3'd4, 2'd0, 1'b1);

    // Upset in one state copy is outvoted, then rewritten on the next edge.
    force dut.st_q2 = ST_FAIL;
    checkOutput("tmr_masked", 3'd4, 2'd0, 1'b1);
    @(negedge CLK);
    #1;
    release dut.st_q2;
    tick(1);
    checkOutput("tmr_after", 3'd4, 2'd0, 1'b1);
    total++;
    if (dut.st_q2 !== ST_RUN) begin
      bad++;
      $display("[TB] FAIL tmr_restore: copy2 got %0d want %0d", dut.st_q2, ST_RUN);
    end

    // Lock glitch during debounce: back to IDLE, GTX_RST stays high.
    applyStimulus(1'b0, 1'b0, 4'b1111, 4'b1111);
    tick(1);  checkOutput("glitch_idle", 3'd0, 2'd0, 1'b1);
    applyStimulus(1'b1, 1'b0, 4'b1111, 4'b1111);
    tick(3);  checkOutput("glitch_lf", 3'd1, 2'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'b1111, 4'b1111);
    for (int g = 0; g < 5; g++) begin
      tick(1); checkOutput("glitch_low", 3'd0, 2'd0, 1'b1);
    end
    applyStimulus(1'b1, 1'b0, 4'b1111, 4'b1111);
    tick(1);  checkOutput("glitch_relock", 3'd1, 2'd0, 1'b1);
    tick(8);  checkOutput("glitch_hold", 3'd2, 2'd0, 1'b1);

    tick(2);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
